// File: rtl/pc_stack_unit.sv
// pc_stack_unit
//   Program counter plus bounded return-address stack for the multicycle core.
//   Each commit selects the next PC (sequential, branch/call, jump, return or
//   halt) and optionally pushes the return address pc+1 or pops one off.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   pc_write          commit strobe
//   pc_src            next-PC select
//   push, pop         CALL / RET stack requests
//   cond_ok           branch/call condition
//   target_addr       branch/call/JR target
//   jump_addr         JPC target
//   pc, pc_plus1      current PC (registered) and pc+1 (combinational)
//   halted            sticky halt flag
//   stack_empty/full  occupancy flags
//   stack_depth       occupied entries
//   stack_err         sticky overflow/underflow/push-pop conflict
module pc_stack_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    STACK_DEPTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pc_write,
    input  logic [2:0]                     pc_src,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           cond_ok,
    input  logic [ADDR_WIDTH-1:0]          target_addr,
    input  logic [ADDR_WIDTH-1:0]          jump_addr,
    output logic [ADDR_WIDTH-1:0]          pc,
    output logic [ADDR_WIDTH-1:0]          pc_plus1,
    output logic                           halted,
    output logic                           stack_empty,
    output logic                           stack_full,
    output logic [$clog2(STACK_DEPTH):0]   stack_depth,
    output logic                           stack_err
);
    localparam int IW  = $clog2(STACK_DEPTH);
    localparam int SPW = IW + 1;

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t                  state, nxt_state;
    logic [SPW-1:0]          sp, nxt_sp;
    logic [ADDR_WIDTH-1:0]   nxt_pc;
    logic                    wr_en, err_set;
    logic [IW-1:0]           top_idx;
    logic [ADDR_WIDTH-1:0]   mem [STACK_DEPTH];

    assign pc_plus1    = pc + 1'b1;
    assign stack_depth = sp;
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SPW'(STACK_DEPTH));
    assign halted      = (state == HALT);
    // When full, sp[IW-1:0] is 0 and the decrement wraps to the last slot.
    assign top_idx     = sp[IW-1:0] - IW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            pc        <= RESET_PC;
            sp        <= '0;
            stack_err <= 1'b0;
        end else begin
            state <= nxt_state;
            pc    <= nxt_pc;
            sp    <= nxt_sp;
            if (err_set) stack_err <= 1'b1;
        end
    end

    // Stack storage is not reset; occupancy is tracked solely by sp.
    always_ff @(posedge clk) begin
        if (wr_en) mem[sp[IW-1:0]] <= pc_plus1;
    end

    always_comb begin
        nxt_state = state;
        nxt_pc    = pc;
        nxt_sp    = sp;
        wr_en     = 1'b0;
        err_set   = 1'b0;
        if (state == RUN && pc_write) begin
            nxt_pc = pc_plus1;
            case (pc_src)
                3'b000: begin
                    // RET only when pop is requested alone; the conflict case
                    // is handled below.
                    if (pop && !push) begin
                        if (stack_empty) begin
                            err_set = 1'b1;
                        end else begin
                            nxt_pc = mem[top_idx];
                            nxt_sp = sp - 1'b1;
                        end
                    end
                end
                3'b001: if (cond_ok) nxt_pc = target_addr;
                3'b100: nxt_pc = jump_addr;
                3'b101: begin
                    nxt_pc    = pc;
                    nxt_state = HALT;
                end
                default: ;
            endcase
            if (push && pop) begin
                err_set = 1'b1;
                if (pc_src != 3'b101) nxt_pc = pc_plus1;
            end else if (push) begin
                // Push is independent of the PC select and of cond_ok.
                if (stack_full) begin
                    err_set = 1'b1;
                end else begin
                    wr_en  = 1'b1;
                    nxt_sp = sp + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;
    localparam int AW = 32;
    localparam int SD = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          pc_write;
    logic [2:0]    pc_src;
    logic          push, pop, cond_ok;
    logic [AW-1:0] target_addr, jump_addr;
    logic [AW-1:0] pc, pc_plus1;
    logic          halted, stack_empty, stack_full, stack_err;
    logic [3:0]    stack_depth;

    int checks   = 0;
    int failures = 0;

    pc_stack_unit #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .pc_src(pc_src),
        .push(push), .pop(pop), .cond_ok(cond_ok),
        .target_addr(target_addr), .jump_addr(jump_addr),
        .pc(pc), .pc_plus1(pc_plus1), .halted(halted),
        .stack_empty(stack_empty), .stack_full(stack_full),
        .stack_depth(stack_depth), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic commit(input logic [2:0] src, input logic pu, input logic po,
                          input logic c, input logic [AW-1:0] tgt, input logic [AW-1:0] jmp);
        @(negedge clk);
        pc_write = 1'b1; pc_src = src; push = pu; pop = po; cond_ok = c;
        target_addr = tgt; jump_addr = jmp;
        @(posedge clk);
        #1;
        pc_write = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; pc_write = 0; pc_src = 3'b010; push = 0; pop = 0;
        cond_ok = 0; target_addr = '0; jump_addr = '0;

        // Reset state
        do_reset();
        chk("rst_pc", pc, 32'h0);
        chk("rst_empty", AW'(stack_empty), 1);
        chk("rst_full", AW'(stack_full), 0);
        chk("rst_depth", AW'(stack_depth), 0);
        chk("rst_halted", AW'(halted), 0);
        chk("rst_err", AW'(stack_err), 0);
        release_reset();

        // Sequential fetch
        for (int i = 1; i <= 3; i++) begin
            commit(3'b010, 0, 0, 0, '0, '0);
            chk("seq_pc", pc, AW'(i));
        end
        chk("seq_empty", AW'(stack_empty), 1);
        chk("seq_err", AW'(stack_err), 0);

        // CALL / RET
        commit(3'b100, 0, 0, 0, '0, 32'd5);
        chk("jmp5", pc, 32'd5);
        commit(3'b001, 1, 0, 1, 32'd40, '0);
        chk("call_pc", pc, 32'd40);
        chk("call_depth", AW'(stack_depth), 1);
        commit(3'b000, 0, 1, 0, '0, '0);
        chk("ret_pc", pc, 32'd6);
        chk("ret_empty", AW'(stack_empty), 1);

        // Branch not taken, then jump; RET select without pop is sequential
        commit(3'b000, 0, 0, 0, '0, '0);
        chk("src0_nopop", pc, 32'd7);
        commit(3'b001, 0, 0, 0, 32'd99, '0);
        chk("br_nt", pc, 32'd8);
        commit(3'b100, 0, 0, 0, '0, 32'h100);
        chk("jmp100", pc, 32'h100);

        // Overflow: 8 CALLs fill the stack, the 9th errors
        for (int i = 0; i < 8; i++) begin
            commit(3'b001, 1, 0, 1, 32'h200 + 32'(i) * 32'h10, '0);
        end
        chk("ovf_pc8", pc, 32'h270);
        chk("ovf_full", AW'(stack_full), 1);
        chk("ovf_err_pre", AW'(stack_err), 0);
        commit(3'b001, 1, 0, 1, 32'h280, '0);
        chk("ovf_pc9", pc, 32'h280);
        chk("ovf_err", AW'(stack_err), 1);
        chk("ovf_depth", AW'(stack_depth), 8);

        // Unwind: pops return 0x261, 0x251 ... 0x201, then 0x101
        for (int i = 0; i < 8; i++) begin
            commit(3'b000, 0, 1, 0, '0, '0);
            chk("unwind_pc", pc, (i < 7) ? (32'h261 - 32'(i) * 32'h10) : 32'h101);
        end
        commit(3'b000, 0, 1, 0, '0, '0);
        chk("unf_pc", pc, 32'h102);
        chk("unf_depth", AW'(stack_depth), 0);

        // Underflow alone sets the error
        do_reset();
        chk("rst2_err", AW'(stack_err), 0);
        release_reset();
        commit(3'b000, 0, 1, 0, '0, '0);
        chk("unf2_pc", pc, 32'd1);
        chk("unf2_err", AW'(stack_err), 1);

        // Push/pop conflict
        do_reset();
        release_reset();
        commit(3'b001, 1, 1, 1, 32'h77, '0);
        chk("conf_pc", pc, 32'd1);
        chk("conf_depth", AW'(stack_depth), 0);
        chk("conf_err", AW'(stack_err), 1);

        // Halt, then async reset mid-cycle
        commit(3'b100, 0, 0, 0, '0, 32'd12);
        commit(3'b101, 0, 0, 0, '0, '0);
        chk("halt_flag", AW'(halted), 1);
        chk("halt_pc", pc, 32'd12);
        commit(3'b100, 0, 0, 0, '0, 32'h55);
        commit(3'b001, 1, 0, 1, 32'h66, '0);
        chk("halt_hold_pc", pc, 32'd12);
        chk("halt_hold_depth", AW'(stack_depth), 0);
        do_reset();
        chk("midrst_pc", pc, 32'd0);
        chk("midrst_halted", AW'(halted), 0);
        release_reset();

        // Wrap
        commit(3'b100, 0, 0, 0, '0, 32'hFFFF_FFFF);
        chk("wrap_plus1", pc_plus1, 32'd0);
        commit(3'b010, 0, 0, 0, '0, '0);
        chk("wrap_pc", pc, 32'd0);

        // Hold with pc_write low
        commit(3'b001, 1, 0, 1, 32'h30, '0);
        chk("hold_pre_pc", pc, 32'h30);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pc_src = 3'(i); push = i[0]; pop = i[1]; cond_ok = 1'b1;
            jump_addr = 32'h999; target_addr = 32'h888;
        end
        @(posedge clk);
        #1;
        chk("hold_pc", pc, 32'h30);
        chk("hold_depth", AW'(stack_depth), 1);
        chk("hold_err", AW'(stack_err), 0);
        chk("hold_halted", AW'(halted), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
